// File: rtl/alu_cmd_issue.sv
`timescale 1ns/1ps
// alu_cmd_issue: command FIFO feeding a registered operand stage for cla_alu,
// a registered result stage capturing cla_alu's combinational z/v, and a
// saturating count of overflow results.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload stable until it sees
// ready; ready never depends combinationally on the same-side valid or on
// the opposite-side ready (in_ready comes from registered FIFO state only).
module alu_cmd_issue #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [1:0]       in_s,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_v,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * WIDTH + 2;
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Operand stage
    logic [WIDTH-1:0] alu_x_q, alu_x_d;
    logic [WIDTH-1:0] alu_y_q, alu_y_d;
    logic [1:0]       alu_s_q, alu_s_d;
    logic             op_valid_q, op_valid_d;

    // Result stage
    logic [WIDTH-1:0] out_z_q, out_z_d;
    logic             out_v_q, out_v_d;
    logic             out_valid_q, out_valid_d;

    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    // Pipeline control
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             res_load;
    logic             op_adv;
    logic [EW-1:0]    head;

    // Occupancy flags and pipeline advance conditions
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push       = in_valid && !fifo_full;
        res_load   = op_valid_q && (!out_valid_q || out_ready);
        op_adv     = !fifo_empty && (!op_valid_q || res_load);
        head       = mem_q[rd_ptr_q[AW-1:0]];
    end

    // FIFO write and pointer updates; the head is read from registered
    // storage, so a command written this edge is only poppable next cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {in_s, in_y, in_x};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (op_adv) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Operand and result stage next state; drained stages keep their data
    always_comb begin
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        alu_s_d     = alu_s_q;
        op_valid_d  = op_valid_q;
        out_z_d     = out_z_q;
        out_v_d     = out_v_q;
        out_valid_d = out_valid_q;
        if (op_adv) begin
            {alu_s_d, alu_y_d, alu_x_d} = head;
            op_valid_d = 1'b1;
        end else if (res_load) begin
            op_valid_d = 1'b0;
        end
        if (res_load) begin
            out_z_d     = alu_z;
            out_v_d     = alu_v;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Overflow counter: clear wins, otherwise saturating increment
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clr) begin
            ovf_count_d = '0;
        end else if (res_load && alu_v && (ovf_count_q != CNT_MAX)) begin
            ovf_count_d = ovf_count_q + CNT_ONE;
        end
    end

    // State registers; reset discards every queued or in-flight command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_s_q     <= '0;
            op_valid_q  <= 1'b0;
            out_z_q     <= '0;
            out_v_q     <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_s_q     <= alu_s_d;
            op_valid_q  <= op_valid_d;
            out_z_q     <= out_z_d;
            out_v_q     <= out_v_d;
            out_valid_q <= out_valid_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Output mapping
    always_comb begin
        in_ready  = !fifo_full;
        alu_x     = alu_x_q;
        alu_y     = alu_y_q;
        alu_s     = alu_s_q;
        out_valid = out_valid_q;
        out_z     = out_z_q;
        out_v     = out_v_q;
        ovf_count = ovf_count_q;
        busy      = !fifo_empty || op_valid_q || out_valid_q;
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
`timescale 1ns/1ps
// Bench for alu_cmd_issue: a combinational stand-in for cla_alu, a
// scoreboard fed from accepted commands, a vector table, directed corner
// sequences and a randomized stream.
module tb_alu_cmd_issue;

    localparam int WIDTH = 18;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int W     = WIDTH + 1;
    localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
    localparam int SMIN  = -(1 << (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_x = '0;
    logic [WIDTH-1:0] in_y = '0;
    logic [1:0]       in_s = '0;
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [1:0]       alu_s;
    logic [WIDTH-1:0] alu_z;
    logic             alu_v;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_z;
    logic             out_v;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clr = 1'b0;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;
    logic [W-1:0] exp_q[$];

    alu_cmd_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_s(in_s),
        .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s),
        .alu_z(alu_z), .alu_v(alu_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_v(out_v),
        .ovf_count(ovf_count), .ovf_clr(ovf_clr), .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // cla_alu stand-in: bit-level sign rules for overflow
    always_comb begin
        alu_z = '0;
        alu_v = 1'b0;
        case (alu_s)
            2'b00: begin
                alu_z = alu_x + alu_y;
                alu_v = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (alu_z[WIDTH-1] != alu_x[WIDTH-1]);
            end
            2'b01: begin
                alu_z = alu_x - alu_y;
                alu_v = (alu_x[WIDTH-1] != alu_y[WIDTH-1]) && (alu_z[WIDTH-1] != alu_x[WIDTH-1]);
            end
            2'b10: alu_z = alu_x & alu_y;
            default: alu_z = alu_x | alu_y;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result from integer arithmetic and range test
    function automatic logic [W-1:0] ref_result(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [1:0] s);
        int sx;
        int sy;
        int r;
        logic [31:0] ru;
        logic v;
        sx = $signed(x);
        sy = $signed(y);
        v  = 1'b0;
        case (s)
            2'b00: r = sx + sy;
            2'b01: r = sx - sy;
            2'b10: r = int'({14'd0, x & y});
            default: r = int'({14'd0, x | y});
        endcase
        if (s[1] == 1'b0) v = (r > SMAX) || (r < SMIN);
        ru = r;
        return {v, ru[WIDTH-1:0]};
    endfunction

    // Scoreboard: observe both handshakes mid-cycle, pop before push
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("sb_unexpected_result", 64'(exp_q.size()), 64'd1);
                else chk("sb_result", {out_v, out_z}, exp_q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_result(in_x, in_y, in_s));
                n_in++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && busy; i++) tick();
        chk(name, busy, 1'b0);
        chk({name, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    // One command from idle; checks 2-cycle latency and the result
    task automatic send_one(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic [1:0] s, input logic [WIDTH-1:0] ez, input logic ev,
                            input int ecnt);
        in_x = x; in_y = y; in_s = s; in_valid = 1'b1; out_ready = 1'b1;
        tick();                      // E0
        in_valid = 1'b0;
        chk({name, "_lat0"}, out_valid, 1'b0);
        tick();                      // E1
        chk({name, "_lat1"}, out_valid, 1'b0);
        tick();                      // E2
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_z"}, out_z, ez);
        chk({name, "_v"}, out_v, ev);
        chk({name, "_cnt"}, ovf_count, 64'(ecnt));
    endtask

    task automatic new_cmd(input bit rnd);
        if (rnd) begin
            case ($urandom_range(0, 3))
                0: in_x = 18'h1FFFF;
                1: in_x = 18'h20000;
                default: in_x = WIDTH'($urandom);
            endcase
            in_y = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 2)) : WIDTH'($urandom);
            in_s = 2'($urandom_range(0, 3));
        end else begin
            in_x = 18'h1FFFF; in_y = 18'd1; in_s = 2'b00;
        end
    endtask

    // Stream n commands; rnd: random data/valid, out_ready toggling
    task automatic stream(input string name, input int n, input bit rnd);
        int sent = 0;
        int cyc  = 0;
        int out0 = n_out;
        bit acc;
        new_cmd(rnd);
        in_valid = 1'b1;
        while (sent < n && cyc < 20000) begin
            out_ready = rnd ? ~out_ready : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                new_cmd(rnd);
            end
            if (rnd && (acc || !in_valid)) in_valid = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({name, "_sent"}, 64'(sent), 64'(n));
        drain({name, "_drain"});
        chk({name, "_count"}, 64'(n_out - out0), 64'(n));
    endtask

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [1:0]       s;
        logic [WIDTH-1:0] z;
        logic             v;
        int               cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int acc_n;
        int out0;
        bit acc;

        tbl[0] = '{18'd5,      18'd7,      2'b00, 18'd12,     1'b0, 0};
        tbl[1] = '{18'h1FFFF,  18'd1,      2'b00, 18'h20000,  1'b1, 1};
        tbl[2] = '{18'h20000,  18'd1,      2'b01, 18'h1FFFF,  1'b1, 2};
        tbl[3] = '{18'd0,      18'd1,      2'b01, 18'h3FFFF,  1'b0, 2};
        tbl[4] = '{18'h3FFFF,  18'h3FFFF,  2'b00, 18'h3FFFE,  1'b0, 2};
        tbl[5] = '{18'h20000,  18'h20000,  2'b00, 18'h00000,  1'b1, 3};
        tbl[6] = '{18'd100,    18'd300,    2'b01, 18'h3FF38,  1'b0, 3};
        tbl[7] = '{18'h1FFFF,  18'h3FFFF,  2'b01, 18'h20000,  1'b1, 4};

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf_count, 0);
        chk("rst_alu", {alu_s, alu_y, alu_x}, 0);
        chk("rst_out", {out_v, out_z}, 0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 8; i++) begin
            send_one($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].s,
                     tbl[i].z, tbl[i].v, tbl[i].cnt);
        end
        drain("vec_drain");

        // ---------------- backpressure / capacity ----------------
        out_ready = 1'b0;
        acc_n = 0;
        in_y = '0; in_s = 2'b00; in_x = 18'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                acc_n++;
                if (acc_n < 8) in_x = WIDTH'(acc_n + 1);
            end
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(acc_n), 64'(DEPTH + 2));
        chk("bp_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int k = 1; k <= DEPTH + 2; k++) begin
            chk($sformatf("bp_valid%0d", k), out_valid, 1'b1);
            chk($sformatf("bp_order%0d", k), out_z, WIDTH'(k));
            tick();
            if (k == 1) chk("bp_in_ready_back", in_ready, 1'b1);
        end
        chk("bp_empty_after", out_valid, 1'b0);
        drain("bp_drain");

        // ---------------- random stream ----------------
        stream("rand", 1000, 1'b1);

        // ---------------- saturation and clear ----------------
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_idle", ovf_count, 0);
        stream("sat", 300, 1'b0);
        chk("sat_count", ovf_count, 255);
        in_x = 18'h1FFFF; in_y = 18'd1; in_s = 2'b00; in_valid = 1'b1;
        tick();                      // E0
        in_valid = 1'b0;
        tick();                      // E1
        ovf_clr = 1'b1;
        tick();                      // E2: result load and clear together
        ovf_clr = 1'b0;
        chk("clr_same_edge_valid", out_valid, 1'b1);
        chk("clr_same_edge_v", out_v, 1'b1);
        chk("clr_same_edge_cnt", ovf_count, 0);
        drain("clr_drain");

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        in_x = 18'h1FFFF; in_y = 18'd1; in_s = 2'b00; in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_cnt", ovf_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cnt", ovf_count, 0);
        chk("arst_alu_x", alu_x, 0);
        chk("arst_out_z", out_z, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);
        out0 = n_out;
        send_one("post_rst", 18'd2, 18'd3, 2'b00, 18'd5, 1'b0, 0);
        repeat (6) tick();
        chk("post_rst_no_stale", out_valid, 1'b0);
        chk("post_rst_one_out", 64'(n_out - out0), 64'd1);
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Upstream feeder and downstream capture stage for the 18-bit cla_alu.
- Buffers operand/opcode commands in a small FIFO and issues them one per cycle onto the ALU's x/y/s inputs from a register.
- Captures the combinational z/v result into an output register with a valid/ready handshake.
- Keeps a saturating count of overflow results.

Parameters:
- WIDTH, 18, operand/result width; must match cla_alu.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- CNT_W, 8, overflow counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  command present
- in_ready  output  1  FIFO can accept a command
- in_x  input  WIDTH  operand x, two's complement
- in_y  input  WIDTH  operand y, two's complement
- in_s  input  2  opcode, passed to cla_alu unchanged
- alu_x  output  WIDTH  registered operand to cla_alu x
- alu_y  output  WIDTH  registered operand to cla_alu y
- alu_s  output  2  registered opcode to cla_alu s
- alu_z  input  WIDTH  cla_alu result
- alu_v  input  1  cla_alu overflow flag
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer takes the result
- out_z  output  WIDTH  captured result
- out_v  output  1  captured overflow flag
- ovf_count  output  CNT_W  saturating overflow count
- ovf_clr  input  1  synchronous clear of ovf_count
- busy  output  1  FIFO non-empty, or op stage valid, or out_valid

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - FIFO emptied; op_valid=0; out_valid=0.
  - alu_x, alu_y, alu_s, out_z, out_v, ovf_count all =0.
  - in_ready=1 on the first cycle after release.
  - Any in-flight command is discarded; nothing is replayed.
- Handshakes:
  - Input transfer on an edge with in_valid && in_ready.
  - Output transfer on an edge with out_valid && out_ready.
  - in_ready = !fifo_full, combinational from registered state only; no dependence on out_ready, so no combinational path.
- Pipeline: FIFO → op stage (alu_x/y/s registers plus op_valid) → result stage (out_z/out_v registers plus out_valid).
  - res_load = op_valid && (!out_valid || out_ready).
  - op_adv = fifo_nonempty && (!op_valid || res_load).
  - On op_adv: FIFO head popped into alu_x/y/s; op_valid=1.
  - If res_load && !op_adv: op_valid goes to 0; alu_x/y/s hold their last values.
  - On res_load: out_z←alu_z, out_v←alu_v, out_valid=1.
  - If out_ready && out_valid && !res_load: out_valid goes to 0; out_z/out_v hold.
- Latency: command accepted at edge E0 → op stage at E1 → out_valid at E2. Minimum 2 cycles.
- Throughput: 1 command/cycle while out_ready=1.
- Capacity: DEPTH+2 commands in flight (FIFO + op stage + result stage).
- Ordering: strict FIFO; results leave in acceptance order.
- FIFO:
  - Circular buffer; read/write pointers with one extra wrap bit; full/empty derived from the pointers.
  - Push and pop in the same cycle are legal when non-empty and not full; occupancy is unchanged.
  - No push when full (in_ready=0).
  - No pop when empty.
  - No bypass: a command written at E0 is poppable at E1 at the earliest.
- ovf_count:
  - Increments by 1 on each res_load with alu_v=1.
  - Saturates at 2^CNT_W−1; no wrap.
  - ovf_clr=1 forces 0 on that edge and has priority over a simultaneous increment.
- ALU semantics belong to cla_alu. For checking: s=00 is x+y, s=01 is x−y; v flags signed overflow; results wrap modulo 2^WIDTH.

Test Plan:
- x=5, y=7, s=00 with out_ready=1 → out_valid 2 cycles after acceptance; out_z=12, out_v=0; ovf_count=0.
- x=131071, y=1, s=00 → out_z=18'h20000, out_v=1, ovf_count=1. Then x=−131072, y=1, s=01 → out_z=18'h1FFFF, out_v=1, ovf_count=2.
- Backpressure: hold out_ready=0 and drive in_valid=1 with x=1..8.
  - Exactly 6 commands accepted; in_ready=0 afterwards.
  - Raise out_ready → outputs appear on consecutive cycles in order x=1..6; in_ready returns to 1 the cycle after the first pop.
- Streaming 1000 commands with out_ready toggled every cycle → no loss, no duplication, order preserved; busy=0 after the last result transfers.
- 300 overflowing additions → ovf_count saturates at 255. ovf_clr pulsed on the same edge as an overflow result → ovf_count=0.
- rst_n asserted low mid-stream, asynchronously between clock edges, with 3 commands queued → out_valid, op_valid and ovf_count all 0 immediately, with no edge needed. After release, a new command x=2, y=3, s=00 → out_z=5; no stale results appear.
